regfile_32x64: RTL and testbench

- 32-entry x 64-bit register file for the pipelined ARM datapath.
- Write side: a 5-to-32 one-hot write-enable decoder (demux) drives per-register DFF enables, and WriteData fans out to every register.
- Read side: two independent 32:1 read ports built from 2:1 mux trees.
- X31 is hardwired to zero, per the ARM XZR convention.
- Instantiated in the ID stage; written from the WB stage.

---
 rtl/regfile_32x64.sv | 99 +++++++++
 tb/tb_regfile_32x64.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_32x64.sv
// regfile_32x64: 32x64-bit ARM register file. One-hot write decode, two 2:1-mux-tree read ports, X31 reads as zero (XZR).
// Optional build macro REGFILE_BYPASS_EN: same-cycle write-to-read bypass on both read ports.

module regfile_32x64_cell #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

module regfile_32x64_rdmux #(
    parameter int WIDTH  = 64,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic [NREGS-1:0][WIDTH-1:0] regs,
    input  logic [ADDR_W-1:0]           addr,
    output logic [WIDTH-1:0]            data
);
    // Level l halves the candidates using addr[l]. Slot j is rewritten from slots 2j/2j+1,
    // which are never already overwritten within the same level.
    always_comb begin
        logic [NREGS-1:0][WIDTH-1:0] lvl;
        lvl = regs;
        for (int l = 0; l < ADDR_W; l++) begin
            for (int j = 0; j < NREGS/2; j++) begin
                if (j < (NREGS >> (l+1)))
                    lvl[j] = addr[l] ? lvl[2*j+1] : lvl[2*j];
            end
        end
        data = lvl[0];
    end
endmodule

module regfile_32x64 #(
    parameter int WIDTH  = 64,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);
    localparam int ZR = NREGS - 1;

    // XZR has no storage, so its enable slot does not exist at all.
    logic [NREGS-2:0]             enable;
    logic [NREGS-1:0][WIDTH-1:0]  regs;
    logic [1:0][ADDR_W-1:0]       raddr;
    logic [1:0][WIDTH-1:0]        tree;
    logic [1:0][WIDTH-1:0]        rdata;

    for (genvar i = 0; i < NREGS-1; i++) begin : g_reg
        assign enable[i] = RegWrite & (WriteRegister == ADDR_W'(i));

        regfile_32x64_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (enable[i]),
            .d     (WriteData),
            .q     (regs[i])
        );
    end

    assign regs[ZR] = '0;
    assign raddr    = {ReadRegister2, ReadRegister1};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        regfile_32x64_rdmux #(.WIDTH(WIDTH), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_mux (
            .regs (regs),
            .addr (raddr[p]),
            .data (tree[p])
        );

`ifdef REGFILE_BYPASS_EN
        assign rdata[p] = (!reset && RegWrite && (WriteRegister != ADDR_W'(ZR)) &&
                           (raddr[p] == WriteRegister)) ? WriteData : tree[p];
`else
        assign rdata[p] = tree[p];
`endif
    end

    assign ReadData1 = rdata[0];
    assign ReadData2 = rdata[1];
endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: array model checked every negedge, plus directed literal checks.
module tb_regfile_32x64;
    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] PAT = 64'h0101_0101_0101_0101;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_32x64 dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    // Architectural contents as the specification defines them.
    logic [63:0] mdl [32];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) mdl[k] <= '0;
        end else if (RegWrite === 1'b1 && WriteRegister != 5'd31) begin
            mdl[WriteRegister] <= WriteData;
        end
    end

    function automatic logic [63:0] model_read(input logic [4:0] idx);
        if (reset)                return '0;
        if (idx == 5'd31)         return '0;
        if (BYP && RegWrite === 1'b1 && WriteRegister != 5'd31 && idx == WriteRegister)
                                  return WriteData;
        return mdl[idx];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_rd1", ReadData1, model_read(ReadRegister1));
        chk("model_rd2", ReadData2, model_read(ReadRegister2));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            chk({tag, "_rd1"}, ReadData1, (i == 31) ? 64'h0 : 64'(i) * PAT);
            chk({tag, "_rd2"}, ReadData2, (i == 0)  ? 64'h0 : 64'(31 - i) * PAT);
            tick();
        end
    endtask

    initial begin
        reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd31;
        #1 reset = 1'b1;
        tick();
        #1 chk("reset_state_x5", ReadData1, 64'h0);
        tick();
        reset = 1'b0;
        tick();

        // write X5 then pulse reset between edges
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'hDEAD_BEEF_0000_0001;
        tick();
        RegWrite = 1'b0; ReadRegister1 = 5'd5;
        #1 chk("x5_written", ReadData1, 64'hDEAD_BEEF_0000_0001);
        reset = 1'b1;
        #1 chk("async_reset_x5", ReadData1, 64'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 31; i++) begin
            RegWrite = 1'b1; WriteRegister = 5'(i); WriteData = 64'(i) * PAT;
            tick();
        end
        RegWrite = 1'b0;
        sweep("sweep1");

        // XZR write is a no-op
        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
        ReadRegister1 = 5'd31;
        tick();
        RegWrite = 1'b0;
        #1 chk("xzr_after_write", ReadData1, 64'h0);
        tick();
        sweep("sweep2");

        // RegWrite low holds X7
        RegWrite = 1'b0; WriteRegister = 5'd7; WriteData = 64'h1234; ReadRegister1 = 5'd7;
        tick();
        #1 chk("regwrite_low_x7", ReadData1, 64'h0707_0707_0707_0707);

        // same-cycle read of the write target
        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'hAAAA;
        tick();
        WriteData = 64'h5555; ReadRegister1 = 5'd3; ReadRegister2 = 5'd3;
        #1;
        chk("same_cycle_pre_rd1", ReadData1, BYP ? 64'h5555 : 64'hAAAA);
        chk("same_cycle_pre_rd2", ReadData2, BYP ? 64'h5555 : 64'hAAAA);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("same_cycle_post_rd1", ReadData1, 64'h5555);
        chk("same_cycle_post_rd2", ReadData2, 64'h5555);

        // back-to-back writes to one register, last wins
        RegWrite = 1'b1; WriteRegister = 5'd12; WriteData = 64'h1;
        tick();
        WriteData = 64'h2;
        tick();
        WriteData = 64'h3;
        tick();
        RegWrite = 1'b0; ReadRegister1 = 5'd12; ReadRegister2 = 5'd11;
        #1;
        chk("b2b_x12", ReadData1, 64'h3);
        chk("b2b_x11_kept", ReadData2, 64'h0B0B_0B0B_0B0B_0B0B);

        // reset dominates a write across an edge; bypass suppressed during reset
        RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 64'h77;
        ReadRegister1 = 5'd10; ReadRegister2 = 5'd10;
        reset = 1'b1;
        #1 chk("reset_no_bypass", ReadData1, 64'h0);
        tick();
        RegWrite = 1'b0; reset = 1'b0;
        #1 chk("reset_prio_x10", ReadData1, 64'h0);
        tick();
        ReadRegister2 = 5'd5;
        #1;
        chk("reset_prio_x10_later", ReadData1, 64'h0);
        chk("reset_prio_x5", ReadData2, 64'h0);

        // first write after reset release lands
        RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 64'h77;
        tick();
        RegWrite = 1'b0;
        #1 chk("post_reset_write_x10", ReadData1, 64'h77);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
